// File: rtl/boothmult_pkg.sv
// boothmult_pkg: FSM states and Booth-pair encodings for the sequential multiplier.
// The ALU control FSM imports this package too.
package boothmult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {BOOTH_NOP = 2'b00, BOOTH_ADD = 2'b01, BOOTH_SUB = 2'b10} booth_op_t;
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    return {q0, qm1} == 2'b01 ? BOOTH_ADD : {q0, qm1} == 2'b10 ? BOOTH_SUB : BOOTH_NOP;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration, add/sub of the multiplicand then an
// arithmetic right shift of {A,Q,Q-1}.
module booth_step
  import boothmult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] q,
  input  logic           qm1,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] a_next,
  output logic [WIDTH:0] q_next,
  output logic           qm1_next
);
  booth_op_t      op;
  logic [WIDTH:0] sum;
  always_comb begin
    op       = booth_decode(q[0], qm1);
    sum      = op == BOOTH_ADD ? a + m : op == BOOTH_SUB ? a - m : a;
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH:1]};
    qm1_next = q[0];
  end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with signed/unsigned mode,
// abort and back-to-back starts; WIDTH+1 steps per product.
module booth_mult_seq
  import boothmult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic               abort,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  state_t           state, state_n;
  logic [WIDTH:0]   acc, mul, mcand, acc_n, mul_n;
  logic             mul_m1, mul_m1_n;
  logic [CNT_W-1:0] cnt;
  logic             accept, step, last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a(acc), .q(mul), .qm1(mul_m1), .m(mcand),
    .a_next(acc_n), .q_next(mul_n), .qm1_next(mul_m1_n)
  );

  always_comb begin
    accept  = start && (state == IDLE || state == DONE);
    step    = state == BUSY && !abort;
    last    = step && cnt == CNT_W'(1);
    state_n = accept ? BUSY : state == BUSY ? (abort ? IDLE : last ? DONE : BUSY) : IDLE;
    busy    = state == BUSY;
    done    = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // Operands are widened by one bit so both modes share one signed datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mul     <= '0;
      mul_m1  <= 1'b0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc    <= '0;
      mul    <= {is_signed & Q[WIDTH-1], Q};
      mul_m1 <= 1'b0;
      mcand  <= {is_signed & M[WIDTH-1], M};
      cnt    <= CNT_W'(WIDTH + 1);
    end else if (step) begin
      acc    <= acc_n;
      mul    <= mul_n;
      mul_m1 <= mul_m1_n;
      cnt    <= cnt - CNT_W'(1);
      if (last) product <= {acc_n[WIDTH-2:0], mul_n};
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: randomized and directed checks of booth_mult_seq at WIDTH=32
// and WIDTH=8 against a plain-arithmetic product model.
module tb_booth_mult_seq;
  logic        clk = 0, rst_n = 0;
  logic        start32 = 0, s32 = 0, abort32 = 0;
  logic [31:0] m32 = 0, q32 = 0;
  logic [63:0] prod32;
  logic        busy32, done32;
  logic        start8 = 0, s8 = 0, abort8 = 0;
  logic [7:0]  m8 = 0, q8 = 0;
  logic [15:0] prod8;
  logic        busy8, done8;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(s32), .abort(abort32),
    .M(m32), .Q(q32), .product(prod32), .busy(busy32), .done(done32)
  );
  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8), .abort(abort8),
    .M(m8), .Q(q8), .product(prod8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic s, input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] a, b;
    a = s ? {{32{m[31]}}, m} : {32'b0, m};
    b = s ? {{32{q[31]}}, q} : {32'b0, q};
    return a * b;
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] m, input logic [7:0] q);
    int a, b;
    a = s ? int'($signed(m)) : int'(m);
    b = s ? int'($signed(q)) : int'(q);
    return 16'(a * b);
  endfunction

  task automatic op32(input logic s, input logic [31:0] m, input logic [31:0] q,
                      output logic [63:0] p, output int lat);
    s32 = s; m32 = m; q32 = q; start32 = 1;
    @(posedge clk); #1;
    start32 = 0; m32 = $urandom; q32 = $urandom; s32 = ~s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done32 && lat < 200);
    p = prod32;
  endtask

  task automatic op8(input logic s, input logic [7:0] m, input logic [7:0] q,
                     output logic [15:0] p, output int lat);
    s8 = s; m8 = m; q8 = q; start8 = 1;
    @(posedge clk); #1;
    start8 = 0; m8 = 8'($urandom); q8 = 8'($urandom);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done8 && lat < 100);
    p = prod8;
  endtask

  initial begin
    logic [63:0] p, held;
    logic [15:0] p8;
    logic [7:0]  a8, b8;
    logic        sg;
    int          lat, n, seen;
    #12;
    check("rst_product", prod32, 64'd0);
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst_done", {63'd0, done32}, 64'd0);
    rst_n = 1;
    @(posedge clk); #1;
    op32(1, 32'd2, 32'd3, p, lat);
    check("t1_product", p, 64'd6);
    check("t1_latency", 64'(lat), 64'd33);
    check("t1_busy_in_done", {63'd0, busy32}, 64'd0);
    @(posedge clk); #1;
    check("t1_idle_after", {62'd0, busy32, done32}, 64'd0);
    op32(1, -32'sd7, 32'd5, p, lat);
    check("t2_neg", p, 64'hFFFF_FFFF_FFFF_FFDD);
    op32(1, 32'h8000_0000, 32'h8000_0000, p, lat);
    check("t2_minmin", p, 64'h4000_0000_0000_0000);
    op32(0, 32'hFFFF_FFFF, 32'd2, p, lat);
    check("t3_unsigned", p, 64'h0000_0001_FFFF_FFFE);
    op32(1, 32'hFFFF_FFFF, 32'd2, p, lat);
    check("t3_signed", p, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom; sg = 1'($urandom);
      op32(sg, a, b, p, lat);
      check("rand32", p, ref32(sg, a, b));
    end
    // start in BUSY must be ignored
    s32 = 1; m32 = 32'd5; q32 = 32'd7; start32 = 1;
    @(posedge clk); #1;
    m32 = 32'd9;
    repeat (3) @(posedge clk);
    #1 start32 = 0;
    n = 3;
    do begin @(posedge clk); #1; n++; end while (!done32 && n < 200);
    check("t4_ignored_lat", 64'(n), 64'd33);
    check("t4_ignored_prod", prod32, 64'd35);
    @(posedge clk); #1;
    check("t4_no_requeue", {63'd0, busy32}, 64'd0);
    // start held through DONE
    s32 = 0; m32 = 32'd100; q32 = 32'd200; start32 = 1;
    @(posedge clk); #1;
    m32 = 32'd11; q32 = 32'd13;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done32 && n < 200);
    check("t4_b2b_first", prod32, 64'd20000);
    @(posedge clk); #1;
    start32 = 0;
    check("t4_b2b_busy", {63'd0, busy32}, 64'd1);
    n = 1;
    do begin @(posedge clk); #1; n++; end while (!done32 && n < 200);
    check("t4_b2b_gap", 64'(n), 64'd34);
    check("t4_b2b_second", prod32, 64'd143);
    // start+abort together in DONE: start wins
    start32 = 1; abort32 = 1; m32 = 32'd4; q32 = 32'd4;
    @(posedge clk); #1;
    start32 = 0; abort32 = 0;
    check("t5_abort_in_done", {63'd0, busy32}, 64'd1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done32 && n < 200);
    check("t5_abort_in_done_prod", prod32, 64'd16);
    // abort at step 10
    held = prod32;
    s32 = 1; m32 = 32'd1234; q32 = 32'd5678; start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    repeat (9) @(posedge clk);
    #1 abort32 = 1;
    @(posedge clk); #1;
    abort32 = 0;
    check("t5_abort_idle", {62'd0, busy32, done32}, 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen += int'(done32); end
    check("t5_abort_no_done", 64'(seen), 64'd0);
    check("t5_abort_prod", prod32, held);
    // asynchronous reset mid-operation
    s32 = 1; m32 = 32'd77; q32 = 32'd88; start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("t5_rst_prod", prod32, 64'd0);
    check("t5_rst_flags", {62'd0, busy32, done32}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("t5_rst_stays_idle", {62'd0, busy32, done32}, 64'd0);
    // WIDTH=8 random with corners
    for (int i = 0; i < 40; i++) begin
      a8 = i < 4 ? (i[0] ? 8'h80 : 8'hFF) : 8'($urandom);
      b8 = i < 4 ? (i[1] ? 8'h80 : 8'h7F) : 8'($urandom);
      sg = i < 4 ? i[0] : 1'($urandom);
      op8(sg, a8, b8, p8, lat);
      check("w8_product", {48'd0, p8}, {48'd0, ref8(sg, a8, b8)});
      if (i < 4) check("w8_latency", 64'(lat), 64'd9);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
